transformcoder_stream: RTL and testbench
========================================

Name: transformcoder_stream

Overview:
Streaming successor to the fixed 4x4 transform coder. It accepts one 4x4 residual block per cycle under a valid/ready handshake and chains forward transform, quantise, inverse quantise and inverse transform through the existing tran_4x4, quant_4x4, invquant_4x4 and invtran_4x4 stages. It emits reconstructed residuals saturated to OUT_WIDTH. QP is captured per block at runtime and travels with that block down the pipeline, so consecutive blocks may use different QPs. It sits between residual generation and reconstruction in the encoder loop.

Parameters:
BIT_LENGTH, 31, MSB index of internal coefficient words (width BIT_LENGTH+1), passed to all four stages
IN_WIDTH, 8, signed residual input width
OUT_WIDTH, 8, signed reconstructed output width; must be <= BIT_LENGTH+1
QP_MAX, 51, largest legal QP; larger QPs are clamped to this value

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  block present on inputs
in_ready  out  1  block accepted when in_valid && in_ready
in_qp  in  6  QP for this block
in_bypass  in  1  1 = skip coding; output equals input
residuals  in  16 x IN_WIDTH signed  block, raster order, index 0 top-left
out_valid  out  1  reconstructed block present
out_ready  in  1  downstream accepts when out_valid && out_ready
processedres  out  16 x OUT_WIDTH signed  reconstructed block
out_qp  out  6  clamped QP that travelled with the output block
qp_clamped  out  1  one-cycle pulse on the accept cycle when in_qp > QP_MAX

Behaviour:
- Reset, synchronous: out_valid=0, processedres all 0, out_qp=0, qp_clamped=0, all stage valid bits 0; the counter (if built) is 0.
- Reset mid-operation discards all in-flight blocks. out_valid is 0 on the cycle after reset is sampled. in_ready is 0 while reset is high.
- Pipeline: 4 stages S0..S3, each with a valid bit v[i] and sideband {qp_by_6[3:0], qp_mod_6[2:0], qp[5:0], bypass, bypass data}.
- advance = !(v[3] && !out_ready); in_ready = advance && !reset.
- Stage enables are tied to advance, so all stages hold together on a stall.
- On advance: v[0] <= in_valid && in_ready; v[i] <= v[i-1]; sideband shifts with v.
- Bubbles (v=0) shift through but never assert out_valid.
- Latency: a block accepted at cycle t appears with out_valid=1 at t+4 if there is no stall. Throughput is 1 block/cycle.
- Order is preserved. No block is lost or duplicated under any out_ready pattern.
- out_valid = v[3]. processedres and out_qp hold stable while out_valid && !out_ready.
- QP handling at accept:
  - qpc = min(in_qp, QP_MAX).
  - qp_by_6 = floor(qpc/6); qp_mod_6 = qpc - 6*qp_by_6. Computed combinationally for any 6-bit input; no lookup limited to QP_MAX.
  - quant_4x4 uses the S1 sideband and invquant_4x4 uses the S2 sideband, so each block is quantised and dequantised with its own QP.
- quant_4x4 mode input is tied to 0.
- Bypass blocks:
  - Residuals are sign-extended to BIT_LENGTH+1 and carried in the sideband.
  - At S3 the bypass data replaces the invtran output. Latency is identical to coded blocks.
- Output saturation: each coefficient is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. No wrap.
- Simultaneous accept and emit on the same cycle is legal and is the normal full-throughput case.

Optional Feature:
Macro TC_BLKCNT_EN.
- Defined: adds output port blocks_done (16 bits). It increments by 1 on each out_valid && out_ready cycle, wraps 0xFFFF->0x0000, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Bypass block, all residuals = 5, qp=20, in_valid one cycle, out_ready=1 -> out_valid exactly 4 cycles later; processedres all 5; out_qp=20.
- Bypass block, OUT_WIDTH=6, residuals = 127 and -128 -> outputs 31 and -32 (saturated, no wrap).
- Coded block, all residuals 0, qp=28 -> processedres all 0; out_qp=28.
- Back-to-back coded blocks: zero block at qp=0, then zero block at qp=51 -> out_qp sequence 0 then 51 on consecutive cycles.
- Clamp: in_qp=60, accepted -> qp_clamped pulses for 1 cycle; out_qp=51.
- Backpressure: 6 bypass blocks with values 1..6, out_ready held 0 -> in_ready drops after 4 accepts. Then out_ready=1 -> outputs 1..6 in order, no gaps or duplicates. blocks_done=6 when TC_BLKCNT_EN is defined.
- Reset mid-stream: reset asserted while 3 blocks are in flight -> out_valid=0 on the next cycle; no stale block emitted after reset is released.

Source files
------------

// File: rtl/transformcoder_stream.sv
// Streaming 4x4 transform coder: forward transform, quantise, dequantise and inverse transform with per-block QP.
// Optional build macro TC_BLKCNT_EN adds the 16-bit blocks_done output counter.

module tran_4x4 #(
    parameter int BIT_LENGTH = 31
) (
    input  logic signed [BIT_LENGTH:0] din  [16],
    output logic signed [BIT_LENGTH:0] dout [16]
);
    logic signed [BIT_LENGTH:0] t [16];
    logic signed [BIT_LENGTH:0] s03, d03, s12, d12;

    always_comb begin
        t    = '{default: '0};
        dout = '{default: '0};
        s03 = '0; d03 = '0; s12 = '0; d12 = '0;
        for (int r = 0; r < 4; r++) begin
            s03 = din[4*r] + din[4*r+3];
            d03 = din[4*r] - din[4*r+3];
            s12 = din[4*r+1] + din[4*r+2];
            d12 = din[4*r+1] - din[4*r+2];
            t[4*r]   = s03 + s12;
            t[4*r+1] = (d03 <<< 1) + d12;
            t[4*r+2] = s03 - s12;
            t[4*r+3] = d03 - (d12 <<< 1);
        end
        for (int c = 0; c < 4; c++) begin
            s03 = t[c] + t[c+12];
            d03 = t[c] - t[c+12];
            s12 = t[c+4] + t[c+8];
            d12 = t[c+4] - t[c+8];
            dout[c]    = s03 + s12;
            dout[c+4]  = (d03 <<< 1) + d12;
            dout[c+8]  = s03 - s12;
            dout[c+12] = d03 - (d12 <<< 1);
        end
    end
endmodule

module quant_4x4 #(
    parameter int BIT_LENGTH = 31
) (
    input  logic                       mode,
    input  logic [3:0]                 qp_by_6,
    input  logic [2:0]                 qp_mod_6,
    input  logic signed [BIT_LENGTH:0] din  [16],
    output logic signed [BIT_LENGTH:0] dout [16]
);
    typedef logic [BIT_LENGTH:0] uword_t;

    // Multiplier classes: even/even positions, odd/odd positions, mixed.
    function automatic logic [13:0] mf(input logic [2:0] m, input logic odd_row, input logic odd_col);
        logic [13:0] a, b, c;
        case (m)
            3'd0:    begin a = 14'd13107; b = 14'd5243; c = 14'd8066; end
            3'd1:    begin a = 14'd11916; b = 14'd4660; c = 14'd7490; end
            3'd2:    begin a = 14'd10082; b = 14'd4194; c = 14'd6554; end
            3'd3:    begin a = 14'd9362;  b = 14'd3647; c = 14'd5825; end
            3'd4:    begin a = 14'd8192;  b = 14'd3355; c = 14'd5243; end
            default: begin a = 14'd7282;  b = 14'd2893; c = 14'd4559; end
        endcase
        if (!odd_row && !odd_col) return a;
        if (odd_row && odd_col) return b;
        return c;
    endfunction

    logic [4:0]  qbits;
    logic [63:0] rnd, mag;
    uword_t      lvl;

    always_comb begin
        qbits = 5'd15 + {1'b0, qp_by_6};
        rnd   = mode ? ((64'd1 << qbits) / 64'd6) : ((64'd1 << qbits) / 64'd3);
        mag   = '0;
        lvl   = '0;
        dout  = '{default: '0};
        for (int i = 0; i < 16; i++) begin
            mag = 64'($unsigned(din[i][BIT_LENGTH] ? -din[i] : din[i]));
            lvl = uword_t'((mag * 64'(mf(qp_mod_6, i[2], i[0])) + rnd) >> qbits);
            dout[i] = din[i][BIT_LENGTH] ? -$signed(lvl) : $signed(lvl);
        end
    end
endmodule

module invquant_4x4 #(
    parameter int BIT_LENGTH = 31
) (
    input  logic [3:0]                 qp_by_6,
    input  logic [2:0]                 qp_mod_6,
    input  logic signed [BIT_LENGTH:0] din  [16],
    output logic signed [BIT_LENGTH:0] dout [16]
);
    function automatic logic [4:0] vq(input logic [2:0] m, input logic odd_row, input logic odd_col);
        logic [4:0] a, b, c;
        case (m)
            3'd0:    begin a = 5'd10; b = 5'd16; c = 5'd13; end
            3'd1:    begin a = 5'd11; b = 5'd18; c = 5'd14; end
            3'd2:    begin a = 5'd13; b = 5'd20; c = 5'd16; end
            3'd3:    begin a = 5'd14; b = 5'd23; c = 5'd18; end
            3'd4:    begin a = 5'd16; b = 5'd25; c = 5'd20; end
            default: begin a = 5'd18; b = 5'd29; c = 5'd23; end
        endcase
        if (!odd_row && !odd_col) return a;
        if (odd_row && odd_col) return b;
        return c;
    endfunction

    always_comb begin
        dout = '{default: '0};
        for (int i = 0; i < 16; i++)
            dout[i] = (din[i] * $signed({1'b0, vq(qp_mod_6, i[2], i[0])})) <<< qp_by_6;
    end
endmodule

module invtran_4x4 #(
    parameter int BIT_LENGTH = 31
) (
    input  logic signed [BIT_LENGTH:0] din  [16],
    output logic signed [BIT_LENGTH:0] dout [16]
);
    localparam logic signed [BIT_LENGTH:0] RND = 32;

    logic signed [BIT_LENGTH:0] t [16];
    logic signed [BIT_LENGTH:0] e0, e1, e2, e3;

    always_comb begin
        t    = '{default: '0};
        dout = '{default: '0};
        e0 = '0; e1 = '0; e2 = '0; e3 = '0;
        for (int r = 0; r < 4; r++) begin
            e0 = din[4*r] + din[4*r+2];
            e1 = din[4*r] - din[4*r+2];
            e2 = (din[4*r+1] >>> 1) - din[4*r+3];
            e3 = din[4*r+1] + (din[4*r+3] >>> 1);
            t[4*r]   = e0 + e3;
            t[4*r+1] = e1 + e2;
            t[4*r+2] = e1 - e2;
            t[4*r+3] = e0 - e3;
        end
        for (int c = 0; c < 4; c++) begin
            e0 = t[c] + t[c+8];
            e1 = t[c] - t[c+8];
            e2 = (t[c+4] >>> 1) - t[c+12];
            e3 = t[c+4] + (t[c+12] >>> 1);
            dout[c]    = (e0 + e3 + RND) >>> 6;
            dout[c+4]  = (e1 + e2 + RND) >>> 6;
            dout[c+8]  = (e1 - e2 + RND) >>> 6;
            dout[c+12] = (e0 - e3 + RND) >>> 6;
        end
    end
endmodule

module transformcoder_stream #(
    parameter int BIT_LENGTH = 31,
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int QP_MAX     = 51
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [5:0]                  in_qp,
    input  logic                        in_bypass,
    input  logic signed [IN_WIDTH-1:0]  residuals [16],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] processedres [16],
    output logic [5:0]                  out_qp,
    output logic                        qp_clamped
`ifdef TC_BLKCNT_EN
    ,
    output logic [15:0]                 blocks_done
`endif
);
    typedef logic signed [BIT_LENGTH:0] word_t;
    localparam word_t SAT_MAX = word_t'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam word_t SAT_MIN = -word_t'(2 ** (OUT_WIDTH - 1));

    logic       advance, accept;
    logic [5:0] qpc;
    logic [3:0] qp_by_6_in;
    logic [2:0] qp_mod_6_in;
    logic [3:0] v, sb_byp;
    logic [5:0] sb_qp [4];
    logic [3:0] sb_qb [3];
    logic [2:0] sb_qm [3];
    word_t      recon;

    // S0 holds the sign-extended input, which is also the bypass copy that rides along to S3.
    word_t in_ext [16], s0_data [16], s1_data [16], s2_data [16], s3_data [16];
    word_t b1_data [16], b2_data [16], b3_data [16];
    word_t tran_out [16], quant_out [16], iq_out [16], it_out [16];

    assign advance     = !(v[3] && !out_ready);
    assign in_ready    = advance && !reset;
    assign accept      = in_valid && in_ready;
    assign qpc         = (in_qp > 6'(QP_MAX)) ? 6'(QP_MAX) : in_qp;
    assign qp_by_6_in  = 4'(qpc / 6'd6);
    assign qp_mod_6_in = 3'(qpc % 6'd6);
    assign qp_clamped  = accept && (in_qp > 6'(QP_MAX));
    assign out_valid   = v[3];
    assign out_qp      = sb_qp[3];

    always_comb begin
        in_ext = '{default: '0};
        for (int i = 0; i < 16; i++) in_ext[i] = word_t'(residuals[i]);
    end

    tran_4x4 #(.BIT_LENGTH(BIT_LENGTH)) u_tran (.din(s0_data), .dout(tran_out));

    quant_4x4 #(.BIT_LENGTH(BIT_LENGTH)) u_quant (
        .mode(1'b0), .qp_by_6(sb_qb[1]), .qp_mod_6(sb_qm[1]), .din(s1_data), .dout(quant_out)
    );

    invquant_4x4 #(.BIT_LENGTH(BIT_LENGTH)) u_invquant (
        .qp_by_6(sb_qb[2]), .qp_mod_6(sb_qm[2]), .din(s2_data), .dout(iq_out)
    );

    invtran_4x4 #(.BIT_LENGTH(BIT_LENGTH)) u_invtran (.din(s3_data), .dout(it_out));

    always_ff @(posedge clk) begin
        if (reset) begin
            v      <= '0;
            sb_byp <= '0;
            for (int s = 0; s < 4; s++) sb_qp[s] <= '0;
            for (int s = 0; s < 3; s++) begin
                sb_qb[s] <= '0;
                sb_qm[s] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                s0_data[i] <= '0;
                s1_data[i] <= '0;
                s2_data[i] <= '0;
                s3_data[i] <= '0;
                b1_data[i] <= '0;
                b2_data[i] <= '0;
                b3_data[i] <= '0;
            end
        end else if (advance) begin
            v        <= {v[2:0], accept};
            sb_byp   <= {sb_byp[2:0], in_bypass};
            sb_qp[0] <= qpc;
            sb_qb[0] <= qp_by_6_in;
            sb_qm[0] <= qp_mod_6_in;
            for (int s = 1; s < 4; s++) sb_qp[s] <= sb_qp[s-1];
            for (int s = 1; s < 3; s++) begin
                sb_qb[s] <= sb_qb[s-1];
                sb_qm[s] <= sb_qm[s-1];
            end
            for (int i = 0; i < 16; i++) begin
                s0_data[i] <= in_ext[i];
                s1_data[i] <= tran_out[i];
                s2_data[i] <= quant_out[i];
                s3_data[i] <= iq_out[i];
                b1_data[i] <= s0_data[i];
                b2_data[i] <= b1_data[i];
                b3_data[i] <= b2_data[i];
            end
        end
    end

    always_comb begin
        recon        = '0;
        processedres = '{default: '0};
        for (int i = 0; i < 16; i++) begin
            recon = sb_byp[3] ? b3_data[i] : it_out[i];
            if (recon > SAT_MAX)      processedres[i] = SAT_MAX[OUT_WIDTH-1:0];
            else if (recon < SAT_MIN) processedres[i] = SAT_MIN[OUT_WIDTH-1:0];
            else                      processedres[i] = recon[OUT_WIDTH-1:0];
        end
    end

`ifdef TC_BLKCNT_EN
    always_ff @(posedge clk) begin
        if (reset)                 blocks_done <= '0;
        else if (v[3] && out_ready) blocks_done <= blocks_done + 16'd1;
    end
`endif
endmodule

// File: tb/tb_transformcoder_stream.sv
// Directed self-checking bench for transformcoder_stream; a second instance with OUT_WIDTH=6 covers saturation.
// Build with TC_BLKCNT_EN defined to also check blocks_done.

module tb_transformcoder_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, in_valid, in_bypass, out_ready;
    logic [5:0]        in_qp;
    logic signed [7:0] residuals [16];

    logic              in_ready, out_valid, qp_clamped;
    logic [5:0]        out_qp;
    logic signed [7:0] processedres [16];

    logic              in_ready6, out_valid6, qp_clamped6;
    logic [5:0]        out_qp6;
    logic signed [5:0] processedres6 [16];
`ifdef TC_BLKCNT_EN
    logic [15:0]       blocks_done, blocks_done6;
`endif

    int checks = 0;
    int errors = 0;

    transformcoder_stream dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_qp(in_qp),
        .in_bypass(in_bypass), .residuals(residuals), .out_valid(out_valid), .out_ready(out_ready),
        .processedres(processedres), .out_qp(out_qp), .qp_clamped(qp_clamped)
`ifdef TC_BLKCNT_EN
        , .blocks_done(blocks_done)
`endif
    );

    transformcoder_stream #(.OUT_WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6), .in_qp(in_qp),
        .in_bypass(in_bypass), .residuals(residuals), .out_valid(out_valid6), .out_ready(out_ready),
        .processedres(processedres6), .out_qp(out_qp6), .qp_clamped(qp_clamped6)
`ifdef TC_BLKCNT_EN
        , .blocks_done(blocks_done6)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block(input int val, input logic [5:0] qp, input logic byp);
        in_valid  = 1'b1;
        in_qp     = qp;
        in_bypass = byp;
        for (int i = 0; i < 16; i++) residuals[i] = 8'(val);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1; out_ready = 1'b1;
        set_block(9, 6'd60, 1'b1);
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_qp !== 6'd0) begin errors++; $display("FAIL reset_out_qp: got %0d want 0", out_qp); end
        checks++; if (qp_clamped !== 1'b0) begin errors++; $display("FAIL reset_qp_clamped: got %b want 0", qp_clamped); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (processedres[i] !== 8'sd0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_data: %0d nonzero, res[0]=%0d want 0", bad, processedres[0]); end
`ifdef TC_BLKCNT_EN
        checks++; if (blocks_done !== 16'd0) begin errors++; $display("FAIL reset_blocks_done: got %0d want 0", blocks_done); end
`endif
        reset = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bypass_latency();
        int bad;
        out_ready = 1'b1;
        set_block(5, 6'd20, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            checks++;
            if (out_valid !== (k == 4)) begin
                errors++; $display("FAIL bypass_latency: cycle %0d out_valid=%b want %b", k, out_valid, (k == 4));
            end
            if (k == 4) begin
                bad = 0;
                for (int i = 0; i < 16; i++) if (processedres[i] !== 8'sd5) bad++;
                checks++; if (bad != 0) begin errors++; $display("FAIL bypass_data: res[0]=%0d want 5", processedres[0]); end
                checks++; if (out_qp !== 6'd20) begin errors++; $display("FAIL bypass_qp: got %0d want 20", out_qp); end
            end
        end
    endtask

    task automatic test_saturation();
        int bad, bad6;
        logic signed [7:0] e;
        logic signed [5:0] e6;
        out_ready = 1'b1;
        set_block(0, 6'd0, 1'b1);
        for (int i = 0; i < 16; i++) residuals[i] = (i % 2 == 0) ? 8'h7F : 8'h80;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (out_valid6 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", out_valid6); end
        bad = 0; bad6 = 0;
        for (int i = 0; i < 16; i++) begin
            e  = (i % 2 == 0) ? 8'h7F : 8'h80;
            e6 = (i % 2 == 0) ? 6'd31 : 6'h20;
            if (processedres[i] !== e) bad++;
            if (processedres6[i] !== e6) bad6++;
        end
        checks++; if (bad6 != 0) begin errors++; $display("FAIL sat_out6: res6[0]=%0d res6[1]=%0d want 31 -32", processedres6[0], processedres6[1]); end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_out8: res[0]=%0d res[1]=%0d want 127 -128", processedres[0], processedres[1]); end
    endtask

    task automatic test_coded_zero();
        int bad;
        out_ready = 1'b1;
        set_block(0, 6'd28, 1'b0);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_qp !== 6'd28) begin
            errors++; $display("FAIL coded_zero_qp: valid=%b qp=%0d want 1 28", out_valid, out_qp);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (processedres[i] !== 8'sd0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL coded_zero_data: res[0]=%0d want 0", processedres[0]); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_block(0, 6'd0, 1'b0);
        tick();
        set_block(0, 6'd51, 1'b0);
        #1;
        checks++; if (qp_clamped !== 1'b0) begin errors++; $display("FAIL b2b_no_clamp: got %b want 0", qp_clamped); end
        tick();
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_qp !== 6'd0) begin
            errors++; $display("FAIL b2b_first: valid=%b qp=%0d want 1 0", out_valid, out_qp);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_qp !== 6'd51) begin
            errors++; $display("FAIL b2b_second: valid=%b qp=%0d want 1 51", out_valid, out_qp);
        end
    endtask

    // DC-only blocks: 10@qp0 -> 10, 10@qp28 -> 8, -10@qp0 -> -10 after the full coding loop.
    task automatic test_per_block_qp();
        int vals [3] = '{10, 10, -10};
        int qps  [3] = '{0, 28, 0};
        int exps [3] = '{10, 8, -10};
        int bad;
        logic signed [7:0] e;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_block(vals[b], 6'(qps[b]), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            e = 8'(exps[b]);
            bad = 0;
            for (int i = 0; i < 16; i++) if (processedres[i] !== e) bad++;
            checks++;
            if (out_valid !== 1'b1 || bad != 0 || out_qp !== 6'(qps[b])) begin
                errors++;
                $display("FAIL coded_qp blk%0d: valid=%b res[0]=%0d res[5]=%0d qp=%0d want 1 %0d %0d %0d",
                         b, out_valid, processedres[0], processedres[5], out_qp, exps[b], exps[b], qps[b]);
            end
        end
    endtask

    task automatic test_clamp();
        int bad;
        out_ready = 1'b1;
        set_block(3, 6'd60, 1'b1);
        #1;
        checks++; if (qp_clamped !== 1'b1) begin errors++; $display("FAIL clamp_pulse: got %b want 1", qp_clamped); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (qp_clamped !== 1'b0) begin errors++; $display("FAIL clamp_width: got %b want 0", qp_clamped); end
        tick(); tick(); tick();
        bad = 0;
        for (int i = 0; i < 16; i++) if (processedres[i] !== 8'sd3) bad++;
        checks++; if (out_valid !== 1'b1 || out_qp !== 6'd51 || bad != 0) begin
            errors++; $display("FAIL clamp_out: valid=%b qp=%0d res[0]=%0d want 1 51 3", out_valid, out_qp, processedres[0]);
        end
    endtask

    task automatic test_backpressure();
        int sent, rcv;
        logic signed [7:0] e;
        do_reset();
        sent = 0; rcv = 0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            if (cyc == 8) out_ready = 1'b1;
            if (sent < 6) set_block(sent + 1, 6'd10, 1'b1);
            else in_valid = 1'b0;
            #1;
            if (cyc == 7) begin
                checks++;
                if (sent != 4 || in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_accepts: sent=%0d in_ready=%b want 4 0", sent, in_ready);
                end
            end
            if (rcv > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_gap: out_valid=%b after %0d outputs want 1", out_valid, rcv); end
            end
            if (out_valid && out_ready) begin
                e = 8'(rcv + 1);
                checks++;
                if (processedres[0] !== e || processedres[15] !== e) begin
                    errors++; $display("FAIL drain_order: res[0]=%0d res[15]=%0d want %0d", processedres[0], processedres[15], e);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (rcv != 6) begin errors++; $display("FAIL drain_count: got %0d want 6", rcv); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_dup: out_valid=%b want 0", out_valid); end
`ifdef TC_BLKCNT_EN
        checks++; if (blocks_done !== 16'd6) begin errors++; $display("FAIL blocks_done: got %0d want 6", blocks_done); end
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_block(7 + b, 6'd5, 1'b1);
            tick();
        end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flush: out_valid=%b want 0", out_valid); end
        reset = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d out_valid=%b want 0", k, out_valid); end
        end
`ifdef TC_BLKCNT_EN
        checks++; if (blocks_done !== 16'd0) begin errors++; $display("FAIL mid_blocks_done: got %0d want 0", blocks_done); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b1; in_qp = 6'd0;
        for (int i = 0; i < 16; i++) residuals[i] = 8'sd0;
        test_reset();
        test_bypass_latency();
        test_saturation();
        test_coded_zero();
        test_back_to_back();
        test_per_block_qp();
        test_clamp();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
